fwd_hazard_unit: RTL

Pipeline control block that produces the EX-stage operand-forwarding selects consumed by the forwarding muxes, plus the load-use stall and branch-flush controls for the 5-stage integer pipeline. It keeps its own shadow copy of destination-register state for the EX, MEM and WB stages and advances it in lockstep with the datapath pipeline registers. Selects are resolved during ID and registered, so they are valid from the first cycle the consuming instruction is in EX.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fwd_hazard_unit_if.sv | 47 ++++
 rtl/stage_shadow_reg.sv | 25 ++
 rtl/fwd_hazard_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the integer core: register address width,
// forwarding-mux select encoding and the per-stage destination record
// tracked by the hazard unit.
package cpu_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } stage_info_t;

  // True when the stage will write register r. x0 is hardwired, so it never counts.
  function automatic logic stage_writes(stage_info_t s, reg_addr_t r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle between the pipeline
// datapath (master) and fwd_hazard_unit (slave).
// Optional: FWD_WB_BYPASS_EN adds the ID read-port bypass selects.
interface fwd_hazard_unit_if;
  import cpu_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_use_rs1;
  logic      id_use_rs2;
  reg_addr_t id_rd;
  logic      id_reg_write;
  logic      id_mem_read;
  logic      ex_branch_taken;
  logic      mem_busy;

  fwd_sel_t  forward_a;
  fwd_sel_t  forward_b;
  logic      pc_stall;
  logic      ifid_stall;
  logic      ifid_flush;
  logic      idex_bubble;
`ifdef FWD_WB_BYPASS_EN
  logic      wb_bypass1;
  logic      wb_bypass2;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rd, id_reg_write, id_mem_read, ex_branch_taken, mem_busy,
`ifdef FWD_WB_BYPASS_EN
    input  wb_bypass1, wb_bypass2,
`endif
    input  forward_a, forward_b, pc_stall, ifid_stall, ifid_flush, idex_bubble
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rd, id_reg_write, id_mem_read, ex_branch_taken, mem_busy,
`ifdef FWD_WB_BYPASS_EN
    output wb_bypass1, wb_bypass2,
`endif
    output forward_a, forward_b, pc_stall, ifid_stall, ifid_flush, idex_bubble
  );

endinterface

// File: rtl/stage_shadow_reg.sv
// One shadow pipeline stage of destination-register info. Advances with the
// datapath when enabled; a bubble loads an all-zero (invalid) record.
module stage_shadow_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        bubble,
  input  stage_info_t d,
  output stage_info_t q
);

  // Capture the upstream stage, a bubble, or hold while the pipeline is frozen.
  // NOTE: state registers use non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? stage_info_t'('0) : d;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand-forwarding selects, load-use stall and branch-flush control for
// the 5-stage integer pipeline. Shadows EX/MEM/WB destination info in lockstep
// with the datapath and resolves the forwarding selects during ID.
// Optional: FWD_WB_BYPASS_EN enables the ID read-port bypass from WB.
module fwd_hazard_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
);

  stage_info_t id_info, ex_q, mem_q, wb_q;
  logic        advance;
  logic        load_use;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble;
  fwd_sel_t    fwd_a_q, fwd_b_q;

  assign id_info = '{valid:     bus.id_valid,
                     rd:        bus.id_rd,
                     reg_write: bus.id_reg_write,
                     mem_read:  bus.id_mem_read};

  assign advance = !bus.mem_busy;

  // Youngest producer wins; a load in EX cannot forward yet, so it yields
  // REGFILE (the load-use stall then replaces this with a bubble anyway).
  function automatic fwd_sel_t next_sel(reg_addr_t r, logic used,
                                        stage_info_t ex, stage_info_t mem);
    if (!bus.id_valid || !used)  return FWD_REGFILE;
    if (stage_writes(ex, r))     return ex.mem_read ? FWD_REGFILE : FWD_EXMEM;
    if (stage_writes(mem, r))    return FWD_WB;
    return FWD_REGFILE;
  endfunction

  assign load_use = bus.id_valid && ex_q.mem_read &&
                    ((bus.id_use_rs1 && stage_writes(ex_q, bus.id_rs1)) ||
                     (bus.id_use_rs2 && stage_writes(ex_q, bus.id_rs2)));

  // Stall/flush priority: reset, memory wait, taken branch, load-use.
  // NOTE: every output gets a default before the if-chain so no path leaves
  // one unassigned and a latch is never inferred.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      // all controls stay low while reset is held
    end else if (bus.mem_busy) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  stage_shadow_reg u_ex_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .bubble (idex_bubble),
    .d      (id_info),
    .q      (ex_q)
  );

  stage_shadow_reg u_mem_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  stage_shadow_reg u_wb_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Register the selects so they are valid the first cycle the consumer is in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else if (advance) begin
      fwd_a_q <= idex_bubble ? FWD_REGFILE : next_sel(bus.id_rs1, bus.id_use_rs1, ex_q, mem_q);
      fwd_b_q <= idex_bubble ? FWD_REGFILE : next_sel(bus.id_rs2, bus.id_use_rs2, ex_q, mem_q);
    end
  end

  assign bus.forward_a   = fwd_a_q;
  assign bus.forward_b   = fwd_b_q;
  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;

`ifdef FWD_WB_BYPASS_EN
  assign bus.wb_bypass1 = rst_n && bus.id_use_rs1 && stage_writes(wb_q, bus.id_rs1);
  assign bus.wb_bypass2 = rst_n && bus.id_use_rs2 && stage_writes(wb_q, bus.id_rs2);
`endif

  // The MEM load flag and the WB stage only matter for lockstep tracking
  // (and the optional bypass); collect them so they are not left dangling.
  logic unused_shadow_bits;
  assign unused_shadow_bits = ^{mem_q.mem_read, wb_q};

endmodule
